sisc_exec_unit: RTL and testbench
=================================

# sisc_exec_unit

Execution and sequencing core of the SISC processor. It combines the 32-bit ALU with status-flag generation, the 16-bit branch-target calculator and the multi-cycle control FSM. It sits between the instruction register, register file, status register, PC and data memory. It drives every datapath enable and select, and consumes the current instruction, the register operands, the latched status flags and the PC.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst_f  in  1  asynchronous reset, active-high
- instruction  in  32  current IR: opcode[31:28], mm[27:24], rd[23:20], rs[19:16], rt[15:12], imm[15:0]
- rsa  in  32  register file port A (rs)
- rsb  in  32  register file port B (rt or rd per rb_sel)
- stat  in  4  latched flags {C,V,N,Z} from the status register
- pc_in  in  16  current PC (already incremented past this instruction)
- alu_result  out  32  ALU result
- cc  out  4  new flags {C,V,N,Z}
- stat_en  out  1  status register load enable
- alu_op  out  2  ALU mode: 00 reg-funct, 01 add-immediate, 10 address (rsa+imm), 11 pass rsa
- rf_we  out  1  register file write enable
- wb_sel  out  1  0 = alu_result, 1 = memory read data
- rb_sel  out  1  0 = rt selects port B, 1 = rd selects port B
- pc_sel  out  1  0 = PC+1, 1 = br_addr
- pc_write  out  1  PC load enable
- pc_rst  out  1  PC clear
- ir_load  out  1  IR load enable
- br_sel  out  1  0 = relative target, 1 = absolute target
- mm_sel  out  1  memory address select: 0 = imm, 1 = alu_result[15:0]
- dm_we  out  1  data memory write enable
- br_addr  out  16  branch target

## Operation
- Opcodes:
  - 0000 NOP
  - 0001 ALU register: function is imm[3:0], rd ← f(rsa, rsb)
  - 0011 ADDI: rd ← rsa + sext(imm)
  - 0010 BRA: absolute branch, target = imm
  - 0100 BRR: relative branch, target = pc_in + imm, mod 2^16
  - 1000 LOD: rd ← M[addr]
  - 1001 STR: M[addr] ← rd
  - 1111 HLT
  - Any other opcode executes as NOP.
- Register functions:
  - 0001 ADD, 0010 SUB (rsa−rsb), 0011 NOT rsa
  - 0100 OR, 0101 AND, 0110 XOR
  - 0111 SHL rsa by rsb[4:0], 1000 SHR (logical) rsa by rsb[4:0]
  - Any other function: result 0, stat_en 0, rf_we still asserted.
- Flag rules:
  - Z = result==0; N = result[31].
  - ADD/ADDI: C = carry out of bit 31; V = signed overflow.
  - SUB: C = borrow (rsa < rsb unsigned); V = signed overflow.
  - Logic and shift ops: C = V = 0.
- Branch condition: mm==0000 means always taken; otherwise taken iff (mm & stat) != 0.
- Memory address:
  - mm[3]=1: absolute, mm_sel=0, address = imm.
  - mm[3]=0: indexed, mm_sel=1, alu_op=10, address = rsa+sext(imm).
- alu_op, rb_sel (1 only for STR), br_sel (1 only for BRA), mm_sel and wb_sel (1 only for LOD) are combinational decodes of the current instruction in every state.

## Timing
- FSM states: START0 → START1 → FETCH → DECODE → EXECUTE → MEM → WRITEBACK → FETCH; HALT.
- rst_f high forces START0 immediately. In START0, pc_rst=1 and all other enables are 0.
- START1: all enables 0.
- FETCH: ir_load=1, pc_write=1, pc_sel=0.
- DECODE:
  - BRA/BRR taken: pc_sel=1, pc_write=1 (PC loads br_addr at the end of DECODE).
  - HLT: next state HALT.
- EXECUTE: stat_en=1 only for opcode 0001 with a valid function, or ADDI. The status register updates at the edge ending EXECUTE.
- MEM: dm_we=1 for STR.
- WRITEBACK: rf_we=1 for 0001, ADDI, LOD.
- HALT: all enables 0; left only by reset.
- Non-halting instructions take 5 cycles, FETCH through WRITEBACK.
- Reset asserted mid-instruction: the instruction is abandoned with no rf/dm write.

## Structure
- Package sisc_pkg holds: opcode constants, function constants, alu_op encodings, FSM state enum, flag bit indices.
- One natural sub-module: sisc_alu (combinational ALU + flags).
- FSM, decode and branch adder live in the top.

## Test plan
- Release reset → PC-control outputs: START0 (pc_rst=1), START1, then FETCH (ir_load=1, pc_write=1, pc_sel=0).
- ADD with rsa=0x7FFFFFFF, rsb=1 → alu_result 0x80000000, cc=0110 (C=0, V=1, N=1, Z=0); stat_en only in EXECUTE; rf_we only in WRITEBACK.
- SUB with rsa=5, rsb=5 → result 0, cc=0001; SUB with 1,2 → 0xFFFFFFFF, cc=1010.
- BRR imm=0xFFFE, pc_in=0x0010, mm=0001, stat Z=1 → br_addr 0x000E, pc_write=1 and pc_sel=1 in DECODE; same with stat=0 → no pc_write in DECODE.
- STR indexed rsa=0x20, imm=4 → rb_sel=1, mm_sel=1, alu_result 0x24, dm_we=1 only in MEM, rf_we never.
- HLT → FSM stays in HALT with all enables 0 until rst_f is pulsed.

Source files
------------

// File: rtl/sisc_pkg.sv
// sisc_pkg: shared opcode/function constants, ALU modes, FSM states and flag positions
// for the SISC execution unit.
`default_nettype none

package sisc_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ALU  = 4'b0001;
   localparam logic [3:0] OP_BRA  = 4'b0010;
   localparam logic [3:0] OP_ADDI = 4'b0011;
   localparam logic [3:0] OP_BRR  = 4'b0100;
   localparam logic [3:0] OP_LOD  = 4'b1000;
   localparam logic [3:0] OP_STR  = 4'b1001;
   localparam logic [3:0] OP_HLT  = 4'b1111;

   localparam logic [3:0] FN_ADD = 4'b0001;
   localparam logic [3:0] FN_SUB = 4'b0010;
   localparam logic [3:0] FN_NOT = 4'b0011;
   localparam logic [3:0] FN_OR  = 4'b0100;
   localparam logic [3:0] FN_AND = 4'b0101;
   localparam logic [3:0] FN_XOR = 4'b0110;
   localparam logic [3:0] FN_SHL = 4'b0111;
   localparam logic [3:0] FN_SHR = 4'b1000;

   typedef enum logic [1:0] {
      ALU_REG  = 2'b00,
      ALU_ADDI = 2'b01,
      ALU_ADDR = 2'b10,
      ALU_PASS = 2'b11
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_START0    = 3'd0,
      ST_START1    = 3'd1,
      ST_FETCH     = 3'd2,
      ST_DECODE    = 3'd3,
      ST_EXECUTE   = 3'd4,
      ST_MEM       = 3'd5,
      ST_WRITEBACK = 3'd6,
      ST_HALT      = 3'd7
   } state_e;

   localparam int FLAG_C = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

`default_nettype wire

// File: rtl/sisc_exec_unit_if.sv
// sisc_exec_unit_if: datapath <-> execution unit signal bundle.
`default_nettype none

interface sisc_exec_unit_if;
   logic [31:0] instruction;
   logic [31:0] rsa;
   logic [31:0] rsb;
   logic [3:0]  stat;
   logic [15:0] pc_in;
   logic [31:0] alu_result;
   logic [3:0]  cc;
   logic        stat_en;
   logic [1:0]  alu_op;
   logic        rf_we;
   logic        wb_sel;
   logic        rb_sel;
   logic        pc_sel;
   logic        pc_write;
   logic        pc_rst;
   logic        ir_load;
   logic        br_sel;
   logic        mm_sel;
   logic        dm_we;
   logic [15:0] br_addr;

   modport master (
      output instruction, rsa, rsb, stat, pc_in,
      input  alu_result, cc, stat_en, alu_op, rf_we, wb_sel, rb_sel, pc_sel,
             pc_write, pc_rst, ir_load, br_sel, mm_sel, dm_we, br_addr
   );

   modport slave (
      input  instruction, rsa, rsb, stat, pc_in,
      output alu_result, cc, stat_en, alu_op, rf_we, wb_sel, rb_sel, pc_sel,
             pc_write, pc_rst, ir_load, br_sel, mm_sel, dm_we, br_addr
   );
endinterface

`default_nettype wire

// File: rtl/sisc_alu.sv
// sisc_alu: combinational 32-bit ALU producing result and {C,V,N,Z} flags.
`default_nettype none

module sisc_alu
   import sisc_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [15:0] imm_i,
   input  alu_op_e     alu_op_i,
   input  logic [3:0]  funct_i,
   output logic [31:0] result_o,
   output logic [3:0]  cc_o,
   output logic        fn_valid_o
);

   logic [32:0] sum;
   logic [31:0] res;
   logic [31:0] imm_ext;
   logic        c;
   logic        v;

   assign imm_ext = sext16(imm_i);

   always_comb begin
      sum        = 33'd0;
      res        = 32'd0;
      c          = 1'b0;
      v          = 1'b0;
      fn_valid_o = 1'b1;
      case (alu_op_i)
         ALU_REG: begin
            case (funct_i)
               FN_ADD: begin
                  sum = {1'b0, a_i} + {1'b0, b_i};
                  res = sum[31:0];
                  c   = sum[32];
                  v   = (a_i[31] == b_i[31]) && (res[31] != a_i[31]);
               end
               // 33-bit subtract: bit 32 is set exactly when a < b unsigned (borrow)
               FN_SUB: begin
                  sum = {1'b0, a_i} - {1'b0, b_i};
                  res = sum[31:0];
                  c   = sum[32];
                  v   = (a_i[31] != b_i[31]) && (res[31] != a_i[31]);
               end
               FN_NOT:  res = ~a_i;
               FN_OR:   res = a_i | b_i;
               FN_AND:  res = a_i & b_i;
               FN_XOR:  res = a_i ^ b_i;
               FN_SHL:  res = a_i << b_i[4:0];
               FN_SHR:  res = a_i >> b_i[4:0];
               default: fn_valid_o = 1'b0;
            endcase
         end
         ALU_ADDI, ALU_ADDR: begin
            sum = {1'b0, a_i} + {1'b0, imm_ext};
            res = sum[31:0];
            c   = sum[32];
            v   = (a_i[31] == imm_ext[31]) && (res[31] != a_i[31]);
         end
         default: res = a_i;
      endcase
   end

   assign result_o = res;
   assign cc_o     = {c, v, res[31], (res == 32'd0)};

endmodule

`default_nettype wire

// File: rtl/sisc_exec_unit.sv
// sisc_exec_unit: SISC instruction decode, branch-target adder and multi-cycle control FSM.
`default_nettype none

module sisc_exec_unit
   import sisc_pkg::*;
(
   input  logic            clk,
   input  logic            rst_f,
   sisc_exec_unit_if.slave bus
);

   state_e      state_q;
   state_e      state_d;
   logic [3:0]  opcode;
   logic [3:0]  mm;
   logic [15:0] imm;
   alu_op_e     alu_op;
   logic        is_mem;
   logic        taken;
   logic        fn_valid;
   logic [31:0] alu_result;
   logic [3:0]  alu_cc;
   logic        stat_en, rf_we, pc_sel, pc_write, pc_rst, ir_load, dm_we;

   assign opcode = bus.instruction[31:28];
   assign mm     = bus.instruction[27:24];
   assign imm    = bus.instruction[15:0];
   assign is_mem = (opcode == OP_LOD) || (opcode == OP_STR);
   assign taken  = (mm == 4'b0000) || ((mm & bus.stat) != 4'b0000);

   always_comb begin
      if (opcode == OP_ALU)              alu_op = ALU_REG;
      else if (opcode == OP_ADDI)        alu_op = ALU_ADDI;
      else if (is_mem && !mm[3])         alu_op = ALU_ADDR;
      else                               alu_op = ALU_PASS;
   end

   sisc_alu u_alu (
      .a_i        (bus.rsa),
      .b_i        (bus.rsb),
      .imm_i      (imm),
      .alu_op_i   (alu_op),
      .funct_i    (bus.instruction[3:0]),
      .result_o   (alu_result),
      .cc_o       (alu_cc),
      .fn_valid_o (fn_valid)
   );

   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) state_q <= ST_START0;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_START0:    state_d = ST_START1;
         ST_START1:    state_d = ST_FETCH;
         ST_FETCH:     state_d = ST_DECODE;
         ST_DECODE:    state_d = (opcode == OP_HLT) ? ST_HALT : ST_EXECUTE;
         ST_EXECUTE:   state_d = ST_MEM;
         ST_MEM:       state_d = ST_WRITEBACK;
         ST_WRITEBACK: state_d = ST_FETCH;
         default:      state_d = ST_HALT;
      endcase
   end

   always_comb begin
      stat_en  = 1'b0;
      rf_we    = 1'b0;
      pc_sel   = 1'b0;
      pc_write = 1'b0;
      pc_rst   = 1'b0;
      ir_load  = 1'b0;
      dm_we    = 1'b0;
      case (state_q)
         ST_START0: pc_rst = 1'b1;
         ST_FETCH: begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
         end
         ST_DECODE: begin
            if (((opcode == OP_BRA) || (opcode == OP_BRR)) && taken) begin
               pc_sel   = 1'b1;
               pc_write = 1'b1;
            end
         end
         // Undefined register functions still write back (zero) but leave flags untouched
         ST_EXECUTE:   stat_en = ((opcode == OP_ALU) && fn_valid) || (opcode == OP_ADDI);
         ST_MEM:       dm_we   = (opcode == OP_STR);
         ST_WRITEBACK: rf_we   = (opcode == OP_ALU) || (opcode == OP_ADDI) || (opcode == OP_LOD);
         default: ;
      endcase
   end

   assign bus.alu_result = alu_result;
   assign bus.cc         = alu_cc;
   assign bus.alu_op     = alu_op;
   assign bus.stat_en    = stat_en;
   assign bus.rf_we      = rf_we;
   assign bus.pc_sel     = pc_sel;
   assign bus.pc_write   = pc_write;
   assign bus.pc_rst     = pc_rst;
   assign bus.ir_load    = ir_load;
   assign bus.dm_we      = dm_we;
   assign bus.rb_sel     = (opcode == OP_STR);
   assign bus.br_sel     = (opcode == OP_BRA);
   assign bus.wb_sel     = (opcode == OP_LOD);
   assign bus.mm_sel     = is_mem && !mm[3];
   assign bus.br_addr    = bus.br_sel ? imm : (bus.pc_in + imm);

endmodule

`default_nettype wire

// File: tb/tb_sisc_exec_unit.sv
// tb_sisc_exec_unit: scoreboard bench; per-cycle expectations queued per instruction.
`default_nettype none

module tb_sisc_exec_unit;

   logic clk = 1'b0;
   logic rst_f;
   always #5 clk = ~clk;

   sisc_exec_unit_if bus ();

   sisc_exec_unit dut (
      .clk   (clk),
      .rst_f (rst_f),
      .bus   (bus)
   );

   typedef struct {
      string       tag;
      logic [6:0]  ctrl;   // {stat_en, rf_we, pc_sel, pc_write, pc_rst, ir_load, dm_we}
      logic [5:0]  dec;    // {alu_op[1:0], rb_sel, br_sel, mm_sel, wb_sel}
      logic        chk_res;
      logic [31:0] res;
      logic        chk_cc;
      logic [3:0]  cc;
      logic        chk_br;
      logic [15:0] br;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   localparam logic [6:0] C_NONE  = 7'b0000000;
   localparam logic [6:0] C_RST   = 7'b0000100;
   localparam logic [6:0] C_FETCH = 7'b0001010;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] dec_model(input logic [31:0] instr);
      logic [3:0] op;
      logic [1:0] aop;
      logic       mem;
      op  = instr[31:28];
      mem = (op == 4'h8) || (op == 4'h9);
      if (op == 4'h1)                 aop = 2'b00;
      else if (op == 4'h3)            aop = 2'b01;
      else if (mem && !instr[27])     aop = 2'b10;
      else                            aop = 2'b11;
      return {aop, op == 4'h9, op == 4'h2, mem && !instr[27], op == 4'h8};
   endfunction

   function automatic exp_t mk(input string tag, input logic [6:0] ctrl, input logic [5:0] dec);
      exp_t e;
      e.tag = tag; e.ctrl = ctrl; e.dec = dec;
      e.chk_res = 1'b0; e.res = '0; e.chk_cc = 1'b0; e.cc = '0; e.chk_br = 1'b0; e.br = '0;
      return e;
   endfunction

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ".ctrl"}, {25'd0, bus.stat_en, bus.rf_we, bus.pc_sel, bus.pc_write,
                             bus.pc_rst, bus.ir_load, bus.dm_we}, {25'd0, e.ctrl});
      chk({e.tag, ".dec"}, {26'd0, bus.alu_op, bus.rb_sel, bus.br_sel, bus.mm_sel, bus.wb_sel},
          {26'd0, e.dec});
      if (e.chk_res) chk({e.tag, ".result"}, bus.alu_result, e.res);
      if (e.chk_cc)  chk({e.tag, ".cc"}, {28'd0, bus.cc}, {28'd0, e.cc});
      if (e.chk_br)  chk({e.tag, ".br_addr"}, {16'd0, bus.br_addr}, {16'd0, e.br});
   endtask

   // Runs up to ncyc cycles of one instruction starting with the edge into FETCH.
   task automatic run_instr(input string name, input logic [31:0] instr,
                            input logic [31:0] rsa, input logic [31:0] rsb,
                            input logic [3:0] stat, input logic [15:0] pc, input logic taken,
                            input logic chk_res, input logic [31:0] res,
                            input logic chk_cc, input logic [3:0] cc,
                            input logic chk_br, input logic [15:0] br, input int ncyc);
      exp_t       recs[$];
      exp_t       e;
      logic [3:0] op;
      logic [5:0] dec;
      logic       se, we, dm, bt;
      op  = instr[31:28];
      dec = dec_model(instr);
      se  = ((op == 4'h1) && (instr[3:0] >= 4'h1) && (instr[3:0] <= 4'h8)) || (op == 4'h3);
      we  = (op == 4'h1) || (op == 4'h3) || (op == 4'h8);
      dm  = (op == 4'h9);
      bt  = ((op == 4'h2) || (op == 4'h4)) && taken;
      recs.push_back(mk({name, ".fetch"}, C_FETCH, dec));
      e = mk({name, ".decode"}, {2'b00, bt, bt, 3'b000}, dec);
      e.chk_br = chk_br; e.br = br;
      recs.push_back(e);
      if (op == 4'hF) begin
         for (int i = 2; i < ncyc; i++) recs.push_back(mk({name, ".halt"}, C_NONE, dec));
      end else begin
         e = mk({name, ".execute"}, {se, 6'b000000}, dec);
         e.chk_res = chk_res; e.res = res; e.chk_cc = chk_cc; e.cc = cc;
         recs.push_back(e);
         recs.push_back(mk({name, ".mem"}, {6'b000000, dm}, dec));
         recs.push_back(mk({name, ".writeback"}, {1'b0, we, 5'b00000}, dec));
      end
      for (int i = 0; i < ncyc && i < recs.size(); i++) sb.push_back(recs[i]);
      for (int i = 0; i < ncyc && i < recs.size(); i++) begin
         @(posedge clk);
         #1;
         if (i == 0) begin
            bus.instruction = instr;
            bus.rsa = rsa; bus.rsb = rsb; bus.stat = stat; bus.pc_in = pc;
         end
         #1;
         pop_check();
      end
   endtask

   // Asserts reset between edges; START0 must appear without waiting for a clock.
   task automatic reset_seq(input string name);
      logic [5:0] dec;
      dec = dec_model(bus.instruction);
      #1;
      rst_f = 1'b1;
      #1;
      sb.push_back(mk({name, ".start0_async"}, C_RST, dec));
      pop_check();
      @(posedge clk);
      #2;
      sb.push_back(mk({name, ".start0"}, C_RST, dec));
      pop_check();
      rst_f = 1'b0;
      @(posedge clk);
      #2;
      sb.push_back(mk({name, ".start1"}, C_NONE, dec));
      pop_check();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_f = 1'b1;
      bus.instruction = 32'h0; bus.rsa = 32'h0; bus.rsb = 32'h0;
      bus.stat = 4'h0; bus.pc_in = 16'h0;
      @(posedge clk);
      #2;
      reset_seq("por");

      run_instr("add_ovf", 32'h1031_2001, 32'h7FFF_FFFF, 32'h1, 4'h0, 16'h0, 1'b0,
                1'b1, 32'h8000_0000, 1'b1, 4'b0110, 1'b0, 16'h0, 5);
      run_instr("sub_eq", 32'h1031_2002, 32'h5, 32'h5, 4'h0, 16'h0, 1'b0,
                1'b1, 32'h0, 1'b1, 4'b0001, 1'b0, 16'h0, 5);
      run_instr("sub_brw", 32'h1031_2002, 32'h1, 32'h2, 4'h0, 16'h0, 1'b0,
                1'b1, 32'hFFFF_FFFF, 1'b1, 4'b1010, 1'b0, 16'h0, 5);
      run_instr("shl31", 32'h1031_2007, 32'h1, 32'd31, 4'h0, 16'h0, 1'b0,
                1'b1, 32'h8000_0000, 1'b1, 4'b0010, 1'b0, 16'h0, 5);
      run_instr("shr_mask", 32'h1031_2008, 32'h8000_0000, 32'h3F, 4'h0, 16'h0, 1'b0,
                1'b1, 32'h1, 1'b1, 4'b0000, 1'b0, 16'h0, 5);
      run_instr("xor_self", 32'h1031_2006, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'h0, 16'h0, 1'b0,
                1'b1, 32'h0, 1'b1, 4'b0001, 1'b0, 16'h0, 5);
      run_instr("bad_fn", 32'h1031_200F, 32'h1234_5678, 32'h1, 4'h0, 16'h0, 1'b0,
                1'b1, 32'h0, 1'b0, 4'h0, 1'b0, 16'h0, 5);
      run_instr("addi", 32'h3031_FFFF, 32'h1, 32'h0, 4'h0, 16'h0, 1'b0,
                1'b1, 32'h0, 1'b1, 4'b1001, 1'b0, 16'h0, 5);
      run_instr("brr_tk", 32'h4100_FFFE, 32'h0, 32'h0, 4'b0001, 16'h0010, 1'b1,
                1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 16'h000E, 5);
      run_instr("brr_nt", 32'h4100_FFFE, 32'h0, 32'h0, 4'b0000, 16'h0010, 1'b0,
                1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 16'h000E, 5);
      run_instr("brr_mask", 32'h4600_0005, 32'h0, 32'h0, 4'b0100, 16'h0010, 1'b1,
                1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 16'h0015, 5);
      run_instr("brr_miss", 32'h4B00_0005, 32'h0, 32'h0, 4'b0100, 16'h0010, 1'b0,
                1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 16'h0015, 5);
      run_instr("bra", 32'h2000_1234, 32'h0, 32'h0, 4'h0, 16'h0050, 1'b1,
                1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 16'h1234, 5);
      run_instr("str_idx", 32'h9051_0004, 32'h20, 32'hCAFE, 4'h0, 16'h0, 1'b0,
                1'b1, 32'h24, 1'b0, 4'h0, 1'b0, 16'h0, 5);
      run_instr("lod_idx", 32'h8051_FFFC, 32'h100, 32'h0, 4'h0, 16'h0, 1'b0,
                1'b1, 32'hFC, 1'b0, 4'h0, 1'b0, 16'h0, 5);
      run_instr("lod_abs", 32'h8851_0040, 32'hDEAD, 32'h0, 4'h0, 16'h0, 1'b0,
                1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 16'h0, 5);
      run_instr("nop_ill", 32'h5000_0000, 32'h0, 32'h0, 4'hF, 16'h0, 1'b0,
                1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 16'h0, 5);
      run_instr("hlt", 32'hF000_0000, 32'h0, 32'h0, 4'h0, 16'h0, 1'b0,
                1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 16'h0, 8);
      reset_seq("post_hlt");
      run_instr("add_abort", 32'h1031_2001, 32'h3, 32'h4, 4'h0, 16'h0, 1'b0,
                1'b1, 32'h7, 1'b1, 4'b0000, 1'b0, 16'h0, 3);
      reset_seq("abort");
      run_instr("add_after", 32'h1031_2001, 32'hFFFF_FFFF, 32'h1, 4'h0, 16'h0, 1'b0,
                1'b1, 32'h0, 1'b1, 4'b1001, 1'b0, 16'h0, 5);

      chk("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
